// File: rtl/fifo_stream_drain.sv
// Drain stage for the synchronous FIFO: absorbs its one-cycle read latency,
// re-presents words on a valid/ready stream through a 2-entry skid buffer, and frames packets.
module fifo_stream_drain #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic             fifo_rd_blocked,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_r_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [15:0]      pkt_count
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic             r_infl;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_mem [2];
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_pkt_count;

    logic             w_pop;
    logic             w_push;
    logic             w_acc;
    logic [2:0]       w_level;

    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_mem[r_head];
    assign m_last    = m_valid && (r_idx == LAST_IDX);
    assign pkt_count = r_pkt_count;

    assign w_pop  = m_valid && m_ready;
    assign w_push = r_infl;

    // Slots committed after this edge: the ready->r_en path lets a pop free a slot in the same cycle.
    assign w_level   = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign fifo_r_en = !rst && !fifo_empty && (w_level < 3'd2);
    assign w_acc     = fifo_r_en && !fifo_rd_blocked;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_tail == 1'(gi))) begin
                    r_mem[gi] <= fifo_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_infl      <= 1'b0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_occ       <= 2'd0;
            r_idx       <= '0;
            r_pkt_count <= 16'd0;
        end else begin
            r_infl <= w_acc;
            r_occ  <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
                r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                if (m_last) begin
                    r_pkt_count <= r_pkt_count + 16'd1;
                end
            end
        end
    end

    // A push can only land while a slot is free; a full buffer here means the read gating is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_push |-> (r_occ != 2'd2));

endmodule
